// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory-stage FSM encoding, data-memory width
// and architectural flag bit positions (also consumed by branch logic).
package cpu_pkg;

  localparam int DMEM_ADDR_W = 16;

  localparam int NUM_FLAGS  = 4;
  localparam int FLAG_OV    = 0;
  localparam int FLAG_NEG   = 1;
  localparam int FLAG_ZERO  = 2;
  localparam int FLAG_CARRY = 3;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } stage_state_e;

endpackage

// File: rtl/flag_reg.sv
// Architectural flag register: one flop per flag, each with its own
// load enable; bits without an enable hold their value.
module flag_reg
  import cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_FLAGS-1:0] d,
  input  logic [NUM_FLAGS-1:0] en,
  output logic [NUM_FLAGS-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      for (int i = 0; i < NUM_FLAGS; i++) begin
        if (en[i]) q[i] <= d[i];
      end
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: one load/store per instruction over req/ack,
// upstream stall during the access, flag register and writeback registers.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | ready; accepts an instruction when in_valid && !flush
// ST_ACCESS | data-memory request outstanding; stall upstream
module mem_stage
  import cpu_pkg::*;
#(
  parameter int ADDR_W      = DMEM_ADDR_W,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              flush,
  input  logic [31:0]       alu_result,
  input  logic [31:0]       store_data,
  input  logic [4:0]        dst_reg,
  input  logic              reg_we,
  input  logic              mem_re,
  input  logic              mem_we,
  input  logic              flag_ov_in,
  input  logic              flag_neg_in,
  input  logic              flag_zero_in,
  input  logic              flag_carry_in,
  input  logic              update_flag_ov,
  input  logic              update_flag_neg,
  input  logic              update_flag_zero,
  input  logic              update_flag_carry,
  input  logic              err_clr,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic              stall,
  output logic              out_valid,
  output logic [31:0]       wb_data,
  output logic [4:0]        wb_dst,
  output logic              wb_we,
  output logic              flag_ov,
  output logic              flag_neg,
  output logic              flag_zero,
  output logic              flag_carry,
  output logic              bus_err
);

  localparam logic [7:0] WAIT_LOAD = 8'(TIMEOUT_CYC - 1);

  stage_state_e state, state_nxt;

  logic [7:0] wait_cnt;
  logic [4:0] lat_dst;
  logic       lat_reg_we;
  logic       lat_load;

  logic       accept;
  logic       is_mem;
  logic       ack_done;
  logic       timeout;

  logic [NUM_FLAGS-1:0] flag_d, flag_en, flag_q;

  always_comb begin
    state_nxt = state;
    accept    = (state == ST_IDLE) && in_valid && !flush;
    is_mem    = mem_re || mem_we;
    ack_done  = (state == ST_ACCESS) && dmem_ack;
    // Terminal count of the wait down-counter; a same-edge ack takes priority.
    timeout   = (state == ST_ACCESS) && !dmem_ack && (wait_cnt == 8'd0);
    case (state)
      ST_IDLE:   if (accept && is_mem)    state_nxt = ST_ACCESS;
      ST_ACCESS: if (ack_done || timeout) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  assign stall = (state == ST_ACCESS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      wait_cnt   <= '0;
      lat_dst    <= '0;
      lat_reg_we <= 1'b0;
      lat_load   <= 1'b0;
      out_valid  <= 1'b0;
      wb_data    <= '0;
      wb_dst     <= '0;
      wb_we      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        if (is_mem) begin
          dmem_req   <= 1'b1;
          dmem_we    <= mem_we;
          dmem_addr  <= alu_result[ADDR_W-1:0];
          dmem_wdata <= store_data;
          wait_cnt   <= WAIT_LOAD;
          lat_dst    <= dst_reg;
          lat_reg_we <= reg_we;
          lat_load   <= !mem_we;
        end else begin
          out_valid <= 1'b1;
          wb_data   <= alu_result;
          wb_dst    <= dst_reg;
          wb_we     <= reg_we;
        end
      end else if (ack_done) begin
        dmem_req  <= 1'b0;
        out_valid <= 1'b1;
        wb_dst    <= lat_dst;
        wb_we     <= lat_reg_we && lat_load;
        if (lat_load) wb_data <= dmem_rdata;
      end else if (timeout) begin
        dmem_req  <= 1'b0;
        out_valid <= 1'b1;
        wb_dst    <= lat_dst;
        wb_we     <= 1'b0;
      end else if (state == ST_ACCESS) begin
        wait_cnt <= wait_cnt - 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       bus_err <= 1'b0;
    else if (timeout) bus_err <= 1'b1;
    else if (err_clr) bus_err <= 1'b0;
  end

  always_comb begin
    flag_d = '0;
    flag_d[FLAG_OV]    = flag_ov_in;
    flag_d[FLAG_NEG]   = flag_neg_in;
    flag_d[FLAG_ZERO]  = flag_zero_in;
    flag_d[FLAG_CARRY] = flag_carry_in;
    flag_en = '0;
    if (accept) begin
      flag_en[FLAG_OV]    = update_flag_ov;
      flag_en[FLAG_NEG]   = update_flag_neg;
      flag_en[FLAG_ZERO]  = update_flag_zero;
      flag_en[FLAG_CARRY] = update_flag_carry;
    end
  end

  flag_reg u_flag_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (flag_d),
    .en    (flag_en),
    .q     (flag_q)
  );

  assign flag_ov    = flag_q[FLAG_OV];
  assign flag_neg   = flag_q[FLAG_NEG];
  assign flag_zero  = flag_q[FLAG_ZERO];
  assign flag_carry = flag_q[FLAG_CARRY];

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table for non-memory ops and
// flags, directed memory sequences, then random traffic against a model.
module tb_mem_stage;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 0, flush = 0, reg_we = 0, mem_re = 0, mem_we = 0;
  logic [31:0] alu_result = '0, store_data = '0, dmem_rdata = '0;
  logic [4:0] dst_reg = '0;
  logic [3:0] fin = '0, upd = '0;
  logic err_clr = 0, dmem_ack = 0;
  logic dmem_req, dmem_we, stall, out_valid, wb_we, bus_err;
  logic flag_ov, flag_neg, flag_zero, flag_carry;
  logic [15:0] dmem_addr;
  logic [31:0] dmem_wdata, wb_data;
  logic [4:0] wb_dst;
  logic [3:0] flags;

  int n_tests = 0;
  int n_fail = 0;

  assign flags = {flag_carry, flag_zero, flag_neg, flag_ov};

  always #5 clk = ~clk;

  mem_stage #(.ADDR_W(16), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .flush(flush),
    .alu_result(alu_result), .store_data(store_data), .dst_reg(dst_reg),
    .reg_we(reg_we), .mem_re(mem_re), .mem_we(mem_we),
    .flag_ov_in(fin[0]), .flag_neg_in(fin[1]), .flag_zero_in(fin[2]),
    .flag_carry_in(fin[3]),
    .update_flag_ov(upd[0]), .update_flag_neg(upd[1]),
    .update_flag_zero(upd[2]), .update_flag_carry(upd[3]),
    .err_clr(err_clr), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .stall(stall), .out_valid(out_valid),
    .wb_data(wb_data), .wb_dst(wb_dst), .wb_we(wb_we),
    .flag_ov(flag_ov), .flag_neg(flag_neg), .flag_zero(flag_zero),
    .flag_carry(flag_carry), .bus_err(bus_err)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic v, input logic f, input logic [31:0] alu,
                           input logic [31:0] sd, input logic [4:0] dst,
                           input logic we, input logic re, input logic mwe,
                           input logic [3:0] fi, input logic [3:0] up);
    in_valid = v; flush = f; alu_result = alu; store_data = sd; dst_reg = dst;
    reg_we = we; mem_re = re; mem_we = mwe; fin = fi; upd = up;
  endtask

  typedef struct {
    logic        valid;
    logic        flush;
    logic [31:0] alu;
    logic [4:0]  dst;
    logic        we;
    logic [3:0]  fin;
    logic [3:0]  upd;
    logic        e_ov;
    logic [31:0] e_data;
    logic [4:0]  e_dst;
    logic        e_we;
    logic [3:0]  e_flags;
  } vec_t;

  vec_t vt[7];

  // Reference model state for the random phase
  bit m_acc, m_ov, m_err, m_dst_known, p_load, p_st, p_we, to_hit;
  int m_age;
  logic [4:0] p_dst, m_dst;
  logic [15:0] p_addr;
  logic [31:0] p_wdata, m_data;
  logic [3:0] m_flags;
  bit m_wbwe;

  initial begin
    vt[0] = '{1'b1, 1'b0, 32'h0000_1234, 5'd5,  1'b1, 4'h0, 4'h0, 1'b1, 32'h0000_1234, 5'd5,  1'b1, 4'h0};
    vt[1] = '{1'b1, 1'b0, 32'h0000_0011, 5'd1,  1'b0, 4'hF, 4'hC, 1'b1, 32'h0000_0011, 5'd1,  1'b0, 4'hC};
    vt[2] = '{1'b1, 1'b0, 32'h0000_0022, 5'd2,  1'b1, 4'h0, 4'h0, 1'b1, 32'h0000_0022, 5'd2,  1'b1, 4'hC};
    vt[3] = '{1'b1, 1'b1, 32'h0000_0033, 5'd3,  1'b0, 4'h0, 4'hF, 1'b0, 32'h0000_0022, 5'd2,  1'b1, 4'hC};
    vt[4] = '{1'b0, 1'b0, 32'h0000_0044, 5'd4,  1'b0, 4'h0, 4'hF, 1'b0, 32'h0000_0022, 5'd2,  1'b1, 4'hC};
    vt[5] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 5'd31, 1'b1, 4'h5, 4'h3, 1'b1, 32'hFFFF_FFFF, 5'd31, 1'b1, 4'hD};
    vt[6] = '{1'b1, 1'b0, 32'h0000_0000, 5'd0,  1'b0, 4'h0, 4'hF, 1'b1, 32'h0000_0000, 5'd0,  1'b0, 4'h0};

    #2;
    chk("rst_req", dmem_req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_flags", flags, 0);
    chk("rst_wb", {wb_data, wb_dst, wb_we, bus_err}, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Non-memory ops and flag updates, back to back
    for (int i = 0; i < 7; i++) begin
      set_instr(vt[i].valid, vt[i].flush, vt[i].alu, 32'h0, vt[i].dst, vt[i].we,
                1'b0, 1'b0, vt[i].fin, vt[i].upd);
      tick();
      chk($sformatf("vec%0d_valid", i), out_valid, vt[i].e_ov);
      chk($sformatf("vec%0d_data", i), wb_data, vt[i].e_data);
      chk($sformatf("vec%0d_dst", i), wb_dst, vt[i].e_dst);
      chk($sformatf("vec%0d_we", i), wb_we, vt[i].e_we);
      chk($sformatf("vec%0d_flags", i), flags, vt[i].e_flags);
      chk($sformatf("vec%0d_stall", i), stall, 0);
    end
    in_valid = 0;
    tick();

    // Load, ack on 3rd ACCESS cycle, with a non-mem op held upstream
    set_instr(1, 0, 32'h40, 32'h0, 5'd7, 1, 1, 0, 4'h0, 4'h0);
    tick();
    set_instr(1, 0, 32'h99, 32'h0, 5'd9, 1, 0, 0, 4'h0, 4'h0);
    chk("ld_req", dmem_req, 1);
    chk("ld_addr", dmem_addr, 16'h0040);
    chk("ld_we", dmem_we, 0);
    chk("ld_stall1", stall, 1);
    chk("ld_nov1", out_valid, 0);
    tick();
    chk("ld_stall2", stall, 1);
    tick();
    chk("ld_stall3", stall, 1);
    chk("ld_req3", dmem_req, 1);
    dmem_ack = 1; dmem_rdata = 32'hDEAD_BEEF;
    tick();
    dmem_ack = 0;
    chk("ld_ov", out_valid, 1);
    chk("ld_data", wb_data, 32'hDEAD_BEEF);
    chk("ld_dst", wb_dst, 7);
    chk("ld_wbwe", wb_we, 1);
    chk("ld_stall_end", stall, 0);
    chk("ld_req_end", dmem_req, 0);
    tick();
    chk("held_ov", out_valid, 1);
    chk("held_data", wb_data, 32'h99);
    chk("held_dst", wb_dst, 9);
    in_valid = 0;
    tick();
    chk("held_gap", out_valid, 0);

    // Store with same-cycle ack
    set_instr(1, 0, 32'h123, 32'hA5A5_0001, 5'd3, 1, 0, 1, 4'h0, 4'h0);
    tick();
    in_valid = 0;
    chk("st_we", dmem_we, 1);
    chk("st_wdata", dmem_wdata, 32'hA5A5_0001);
    chk("st_addr", dmem_addr, 16'h0123);
    chk("st_stall", stall, 1);
    dmem_ack = 1;
    tick();
    dmem_ack = 0;
    chk("st_ov", out_valid, 1);
    chk("st_wbwe", wb_we, 0);
    chk("st_data_hold", wb_data, 32'h99);
    chk("st_stall_end", stall, 0);

    // Timeout without ack, then err_clr
    set_instr(1, 0, 32'h80, 32'h0, 5'd4, 1, 1, 0, 4'h0, 4'h0);
    tick();
    in_valid = 0;
    for (int k = 0; k < TO; k++) begin
      chk($sformatf("to_stall%0d", k), stall, 1);
      chk($sformatf("to_noerr%0d", k), bus_err, 0);
      tick();
    end
    chk("to_req", dmem_req, 0);
    chk("to_stall_end", stall, 0);
    chk("to_err", bus_err, 1);
    chk("to_ov", out_valid, 1);
    chk("to_wbwe", wb_we, 0);
    err_clr = 1;
    tick();
    err_clr = 0;
    chk("errclr", bus_err, 0);
    chk("errclr_nov", out_valid, 0);

    // Ack on the last allowed ACCESS cycle wins over timeout
    set_instr(1, 0, 32'h84, 32'h0, 5'd6, 1, 1, 0, 4'h0, 4'h0);
    tick();
    in_valid = 0;
    tick(); tick(); tick();
    dmem_ack = 1; dmem_rdata = 32'h0BAD_F00D;
    tick();
    dmem_ack = 0;
    chk("late_ack_ov", out_valid, 1);
    chk("late_ack_data", wb_data, 32'h0BAD_F00D);
    chk("late_ack_we", wb_we, 1);
    chk("late_ack_err", bus_err, 0);

    // Timeout edge beats a simultaneous err_clr
    set_instr(1, 0, 32'h88, 32'h0, 5'd2, 0, 1, 0, 4'h0, 4'h0);
    tick();
    in_valid = 0;
    tick(); tick(); tick();
    err_clr = 1;
    tick();
    err_clr = 0;
    chk("to_vs_clr", bus_err, 1);

    // Asynchronous reset in the middle of an access
    set_instr(1, 0, 32'h55, 32'h0, 5'd8, 1, 1, 0, 4'hF, 4'hF);
    tick();
    in_valid = 0;
    chk("pre_rst_flags", flags, 4'hF);
    chk("pre_rst_req", dmem_req, 1);
    #3 rst_n = 0;
    #1;
    chk("arst_req", dmem_req, 0);
    chk("arst_stall", stall, 0);
    chk("arst_flags", flags, 0);
    chk("arst_ov", out_valid, 0);
    chk("arst_err", bus_err, 0);
    #2 rst_n = 1;
    tick();
    set_instr(1, 0, 32'h77, 32'h0, 5'd10, 1, 0, 0, 4'h0, 4'h0);
    tick();
    in_valid = 0;
    chk("post_rst_ov", out_valid, 1);
    chk("post_rst_data", wb_data, 32'h77);
    chk("post_rst_dst", wb_dst, 10);

    // Random traffic against the reference model
    rst_n = 0;
    tick();
    rst_n = 1;
    m_acc = 0; m_ov = 0; m_err = 0; m_age = 0; m_dst_known = 1;
    m_data = '0; m_dst = '0; m_wbwe = 0; m_flags = '0;
    p_load = 0; p_st = 0; p_we = 0; p_dst = '0; p_addr = '0; p_wdata = '0;
    for (int c = 0; c < 600; c++) begin
      int op;
      bit re_b, we_b;
      op = int'($urandom_range(0, 2));
      re_b = (op == 1);
      we_b = (op == 2);
      if (we_b && $urandom_range(0, 3) == 0) re_b = 1;
      set_instr($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, $urandom,
                $urandom, 5'($urandom), 1'($urandom), re_b, we_b,
                4'($urandom), 4'($urandom));
      dmem_ack = m_acc && ($urandom_range(0, 2) == 0);
      dmem_rdata = $urandom;
      err_clr = ($urandom_range(0, 7) == 0);

      m_ov = 0;
      to_hit = 0;
      if (!m_acc) begin
        if (in_valid && !flush) begin
          m_flags = (m_flags & ~upd) | (fin & upd);
          if (mem_re || mem_we) begin
            m_acc = 1; m_age = 0;
            p_st = mem_we; p_load = !mem_we; p_we = reg_we; p_dst = dst_reg;
            p_addr = alu_result[15:0]; p_wdata = store_data;
          end else begin
            m_ov = 1; m_data = alu_result; m_dst = dst_reg; m_wbwe = reg_we;
            m_dst_known = 1;
          end
        end
      end else if (dmem_ack) begin
        m_ov = 1; m_acc = 0; m_dst = p_dst; m_dst_known = 1;
        m_wbwe = p_we && p_load;
        if (p_load) m_data = dmem_rdata;
      end else if (m_age == TO - 1) begin
        m_ov = 1; m_acc = 0; m_wbwe = 0; m_dst_known = 0; to_hit = 1;
      end else begin
        m_age++;
      end
      if (to_hit) m_err = 1;
      else if (err_clr) m_err = 0;

      tick();
      chk("r_valid", out_valid, m_ov);
      chk("r_stall", stall, m_acc);
      chk("r_req", dmem_req, m_acc);
      if (m_acc) begin
        chk("r_addr", dmem_addr, p_addr);
        chk("r_dwe", dmem_we, p_st);
        chk("r_wdata", dmem_wdata, p_wdata);
      end
      chk("r_wbdata", wb_data, m_data);
      chk("r_wbwe", wb_we, m_wbwe);
      if (m_dst_known) chk("r_wbdst", wb_dst, m_dst);
      chk("r_flags", flags, m_flags);
      chk("r_err", bus_err, m_err);
    end
    in_valid = 0; dmem_ack = 0; err_clr = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
